lancer_de: RTL and testbench

//  Die-roll engine downstream of the die-type selector: consumes its min_de/max_de

---
 rtl/lancer_de.sv | 156 +++++++++++++++
 tb/tb_lancer_de.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lancer_de.sv
// Die-roll engine: cycles a pseudo-random value in [min_de, max_de] while the
// roll button is held, then decelerates over NB_FREIN steps and settles.
module lancer_de #(
    parameter int DIV_ROULE = 256,
    parameter int NB_FREIN  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lancer,
    input  logic [6:0] min_de,
    input  logic [6:0] max_de,
    output logic [6:0] resultat,
    output logic       maj,
    output logic       en_cours,
    output logic       valide
);

    localparam int TW = $clog2((DIV_ROULE << NB_FREIN) + 1);
    localparam int EW = $clog2(NB_FREIN + 1);

    typedef enum logic [1:0] {ATTENTE, ROULE, FREIN, CALCUL} etat_t;

    etat_t          etat_q, etat_d;
    logic [2:0]     sync_q, sync_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [TW-1:0]  tdiv_q, tdiv_d;
    logic [EW-1:0]  etape_q, etape_d;
    logic [6:0]     brut_q, brut_d;
    logic           ret_frein_q, ret_frein_d;
    logic [6:0]     min_q, min_d;
    logic [7:0]     span_q, span_d;
    logic [6:0]     resultat_q, resultat_d;
    logic           maj_q, maj_d;
    logic           en_cours_q, en_cours_d;
    logic           valide_q, valide_d;

    logic           lancer_s, lancer_d;
    logic [TW-1:0]  periode;

    // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the delayed copy for edge detect
    assign lancer_s = sync_q[1];
    assign lancer_d = sync_q[2];
    assign periode  = TW'(DIV_ROULE) << etape_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        etat_d      = etat_q;
        sync_d      = {sync_q[1:0], lancer};
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        tdiv_d      = tdiv_q;
        etape_d     = etape_q;
        brut_d      = brut_q;
        ret_frein_d = ret_frein_q;
        min_d       = min_q;
        span_d      = span_q;
        resultat_d  = resultat_q;
        maj_d       = 1'b0;
        en_cours_d  = en_cours_q;
        valide_d    = valide_q;

        case (etat_q)
            ATTENTE: begin
                if (lancer_s && !lancer_d) begin
                    min_d      = min_de;
                    span_d     = (max_de >= min_de) ? ({1'b0, max_de} - {1'b0, min_de} + 8'd1) : 8'd1;
                    en_cours_d = 1'b1;
                    valide_d   = 1'b0;
                    tdiv_d     = '0;
                    etat_d     = ROULE;
                end
            end
            ROULE: begin
                if (!lancer_s) begin
                    etape_d = EW'(1);
                    tdiv_d  = '0;
                    etat_d  = FREIN;
                end else if (tdiv_q == TW'(DIV_ROULE - 1)) begin
                    brut_d      = lfsr_q[6:0];
                    ret_frein_d = 1'b0;
                    etat_d      = CALCUL;
                end else begin
                    tdiv_d = tdiv_q + TW'(1);
                end
            end
            FREIN: begin
                if (tdiv_q == periode - TW'(1)) begin
                    brut_d      = lfsr_q[6:0];
                    ret_frein_d = 1'b1;
                    etat_d      = CALCUL;
                end else begin
                    tdiv_d = tdiv_q + TW'(1);
                end
            end
            CALCUL: begin
                // Modulo by repeated subtraction; brut < 128 bounds this to 128 cycles
                if ({1'b0, brut_q} >= span_q) begin
                    brut_d = brut_q - span_q[6:0];
                end else begin
                    resultat_d = min_q + brut_q;
                    maj_d      = 1'b1;
                    tdiv_d     = '0;
                    if (!ret_frein_q) begin
                        etat_d = ROULE;
                    end else if (etape_q < EW'(NB_FREIN)) begin
                        etape_d = etape_q + EW'(1);
                        etat_d  = FREIN;
                    end else begin
                        en_cours_d = 1'b0;
                        valide_d   = 1'b1;
                        etat_d     = ATTENTE;
                    end
                end
            end
            default: etat_d = ATTENTE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            etat_q      <= ATTENTE;
            sync_q      <= '0;
            lfsr_q      <= 16'hACE1;
            tdiv_q      <= '0;
            etape_q     <= '0;
            brut_q      <= '0;
            ret_frein_q <= 1'b0;
            min_q       <= '0;
            span_q      <= 8'd1;
            resultat_q  <= '0;
            maj_q       <= 1'b0;
            en_cours_q  <= 1'b0;
            valide_q    <= 1'b0;
        end else begin
            etat_q      <= etat_d;
            sync_q      <= sync_d;
            lfsr_q      <= lfsr_d;
            tdiv_q      <= tdiv_d;
            etape_q     <= etape_d;
            brut_q      <= brut_d;
            ret_frein_q <= ret_frein_d;
            min_q       <= min_d;
            span_q      <= span_d;
            resultat_q  <= resultat_d;
            maj_q       <= maj_d;
            en_cours_q  <= en_cours_d;
            valide_q    <= valide_d;
        end
    end

    assign resultat = resultat_q;
    assign maj      = maj_q;
    assign en_cours = en_cours_q;
    assign valide   = valide_q;

endmodule

// File: tb/tb_lancer_de.sv
// Scoreboard bench for lancer_de: an event-timeline model of each roll queues the
// expected (cycle, value) of every update; a negedge monitor pops and compares.
module tb_lancer_de;

    localparam int DIV  = 4;
    localparam int NB   = 3;
    localparam int TABN = 1 << 17;

    typedef struct {
        int t;
        int v;
        bit frein;
        bit last;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lancer = 1'b0;
    logic [6:0] min_de = '0;
    logic [6:0] max_de = '0;
    logic [6:0] resultat;
    logic       maj;
    logic       en_cours;
    logic       valide;

    int errors = 0;
    int checks = 0;
    int cyc;
    int last_rel;
    evt_t exp_q[$];
    int frein_t[$];
    logic [15:0] tab [TABN];
    evt_t mon_ev;

    lancer_de #(.DIV_ROULE(DIV), .NB_FREIN(NB)) dut (
        .clk      (clk),
        .reset    (reset),
        .lancer   (lancer),
        .min_de   (min_de),
        .max_de   (max_de),
        .resultat (resultat),
        .maj      (maj),
        .en_cours (en_cours),
        .valide   (valide)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int lfsr_at(input int n);
        if (n < 0 || n >= TABN) begin
            $display("FAIL lfsr_index: cycle %0d outside model table", n);
            $fatal(1, "model table exhausted");
        end
        return int'(tab[n]);
    endfunction

    // Press driven in cycle p, release driven in cycle r. Roll starts at p+3,
    // lancer_s reads 0 from r+2. A draw sampled in cycle c with value s is
    // shown at c+1+s/span+1 as min+s%span.
    task automatic model_roll(input int p, input int r, input int mn, input int mx, output int settle);
        int span, e, f, rel, s, t;
        evt_t ev;
        span = (mx >= mn) ? mx - mn + 1 : 1;
        e    = p + 3;
        rel  = r + 2;
        f    = -1;
        while (f < 0) begin
            if (rel <= e + DIV - 1) begin
                f = ((e > rel) ? e : rel) + 1;
            end else begin
                s  = lfsr_at(e + DIV - 1) & 127;
                ev = '{t: e + DIV + s / span + 1, v: mn + s % span, frein: 1'b0, last: 1'b0};
                exp_q.push_back(ev);
                e  = ev.t;
            end
        end
        for (int k = 1; k <= NB; k++) begin
            t  = DIV << k;
            s  = lfsr_at(f + t - 1) & 127;
            ev = '{t: f + t + s / span + 1, v: mn + s % span, frein: 1'b1, last: (k == NB)};
            exp_q.push_back(ev);
            f  = ev.t;
        end
        settle = f;
    endtask

    task automatic start_roll(input int mn, input int mx, input int hold, input bit chk_start, output int settle);
        int p, r;
        min_de = 7'(mn);
        max_de = 7'(mx);
        @(negedge clk);
        p      = cyc;
        lancer = 1'b1;
        r      = p + hold;
        last_rel = r;
        frein_t.delete();
        model_roll(p, r, mn, mx, settle);
        if (chk_start) begin
            @(negedge clk);
            @(negedge clk);
            check("en_cours_before_start", int'(en_cours), 0);
            @(negedge clk);
            check("en_cours_at_start", int'(en_cours), 1);
            check("valide_at_start", int'(valide), 0);
        end
        while (cyc < r) @(negedge clk);
        lancer = 1'b0;
    endtask

    task automatic finish_roll(input int settle);
        while (cyc < settle + 1) @(negedge clk);
        check("valide_settled", int'(valide), 1);
        check("en_cours_settled", int'(en_cours), 0);
        check("pending_updates", exp_q.size(), 0);
    endtask

    task automatic do_roll(input int mn, input int mx, input int hold, input bit chk_start, output int settle);
        start_roll(mn, mx, hold, chk_start, settle);
        finish_roll(settle);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_resultat", int'(resultat), 0);
        check("reset_maj", int'(maj), 0);
        check("reset_en_cours", int'(en_cours), 0);
        check("reset_valide", int'(valide), 0);
        exp_q.delete();
        lancer = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && maj) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_maj: resultat=%0d at cycle %0d, none expected", resultat, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                check("maj_cycle", cyc, mon_ev.t);
                check("resultat", int'(resultat), mon_ev.v);
                if (mon_ev.frein) frein_t.push_back(cyc);
                if (mon_ev.last) begin
                    check("final_valide", int'(valide), 1);
                    check("final_en_cours", int'(en_cours), 0);
                end
            end
        end
    end

    initial begin
        int settle;
        int ndist;
        bit seen [128];

        tab[0] = 16'hACE1;
        for (int i = 1; i < TABN; i++)
            tab[i] = tab[i-1][0] ? ((tab[i-1] >> 1) ^ 16'hB400) : (tab[i-1] >> 1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("init_resultat", int'(resultat), 0);
        check("init_valide", int'(valide), 0);
        check("init_en_cours", int'(en_cours), 0);

        // Standard d6 roll, first draws after reset come from the 16'hACE1 sequence
        do_roll(1, 6, 200, 1'b1, settle);
        check("frein_pulse_count", frein_t.size(), NB);
        if (frein_t.size() == NB) begin
            check("gap1_min", int'(frein_t[0] - last_rel >= (DIV << 1)), 1);
            check("gap2_min", int'(frein_t[1] - frein_t[0] >= (DIV << 2) + 1), 1);
            check("gap3_min", int'(frein_t[2] - frein_t[1] >= (DIV << 3) + 1), 1);
        end

        // Reset mid-roll: outputs clear without a clock edge, then a fresh roll
        start_roll(1, 6, 40, 1'b0, settle);
        repeat (10) @(negedge clk);
        async_reset();
        do_roll(1, 6, 30, 1'b1, settle);

        // Degenerate bounds
        do_roll(5, 5, 12, 1'b0, settle);
        check("single_value", int'(resultat), 5);
        do_roll(9, 3, 12, 1'b0, settle);
        check("inverted_bounds", int'(resultat), 9);

        // Button chatter and bound changes while braking
        start_roll(10, 60, 30, 1'b0, settle);
        while (cyc < last_rel + 25) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            lancer = ~lancer;
            min_de = 7'($urandom);
            max_de = 7'($urandom);
            @(negedge clk);
        end
        lancer = 1'b0;
        finish_roll(settle);
        check("chatter_range", int'(resultat >= 10 && resultat <= 60), 1);

        // Reset while braking, then a normal roll
        start_roll(1, 40, 20, 1'b0, settle);
        while (cyc < last_rel + 30) @(negedge clk);
        check("braking_en_cours", int'(en_cours), 1);
        async_reset();
        do_roll(1, 40, 15, 1'b1, settle);

        // Back-to-back d100 rolls
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        for (int n = 0; n < 500; n++) begin
            do_roll(1, 100, int'($urandom_range(1, 8)), 1'b0, settle);
            check("d100_range", int'(resultat >= 1 && resultat <= 100), 1);
            seen[resultat] = 1'b1;
        end
        ndist = 0;
        for (int i = 0; i < 128; i++) if (seen[i]) ndist++;
        check("d100_distinct_ge_60", int'(ndist >= 60), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
